// File: rtl/reversalmb_module_initiator_pkg.sv
// Shared REVERSALMB definitions: sideband message codes, mainband generator
// control words, lane count and the initiator state encoding.
package reversalmb_module_initiator_pkg;

   localparam int RMB_LANES          = 16;
   localparam int RMB_PASS_THRESHOLD = 8;

   localparam logic [3:0] MSG_INIT_REQ         = 4'b0001;
   localparam logic [3:0] MSG_INIT_RESP        = 4'b0010;
   localparam logic [3:0] MSG_CLEAR_ERROR_REQ  = 4'b0011;
   localparam logic [3:0] MSG_CLEAR_ERROR_RESP = 4'b0100;
   localparam logic [3:0] MSG_RESULT_REQ       = 4'b0101;
   localparam logic [3:0] MSG_RESULT_RESP      = 4'b0110;
   localparam logic [3:0] MSG_DONE_REQ         = 4'b0111;
   localparam logic [3:0] MSG_DONE_RESP        = 4'b1000;

   localparam logic [1:0] CW_IDLE       = 2'b00;
   localparam logic [1:0] CW_CLEAR_LFSR = 2'b01;
   localparam logic [1:0] CW_SEND_ID    = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_INIT_REQ,
      ST_WAIT_INIT_RESP,
      ST_SEND_CLEAR_REQ,
      ST_WAIT_CLEAR_RESP,
      ST_SEND_PATTERN,
      ST_SEND_RESULT_REQ,
      ST_WAIT_RESULT_RESP,
      ST_EVALUATE,
      ST_SEND_DONE_REQ,
      ST_WAIT_DONE_RESP,
      ST_TEST_FINISHED,
      ST_ERROR
   } rmb_state_e;

   function automatic logic is_send_state(input rmb_state_e s);
      return s inside {ST_SEND_INIT_REQ, ST_SEND_CLEAR_REQ,
                       ST_SEND_RESULT_REQ, ST_SEND_DONE_REQ};
   endfunction

endpackage

// File: rtl/reversalmb_module_initiator_if.sv
// Sideband, mainband-generator and MBINIT signals of the REVERSALMB initiator.
interface reversalmb_module_initiator_if #(
   parameter int LANES = reversalmb_module_initiator_pkg::RMB_LANES
);
   logic             i_REVERSAL_EN;
   logic             i_rx_msg_valid;
   logic [3:0]       i_decoded_SB_msg;
   logic [LANES-1:0] i_rx_data_bus;
   logic             i_SB_Busy;
   logic             i_falling_edge_busy;
   logic             i_rx_wrapper_valid;
   logic             i_pattern_gen_done;
   logic [3:0]       o_encoded_SB_msg_tx;
   logic             o_valid_tx;
   logic [1:0]       o_mainband_pattern_generator_cw;
   logic             o_lane_reversal;
   logic             o_current_die_repeating_reversalmb;
   logic             o_tx_reversalmb_done;
   logic             o_reversalmb_error;

   modport master (
      input  i_REVERSAL_EN, i_rx_msg_valid, i_decoded_SB_msg, i_rx_data_bus,
             i_SB_Busy, i_falling_edge_busy, i_rx_wrapper_valid, i_pattern_gen_done,
      output o_encoded_SB_msg_tx, o_valid_tx, o_mainband_pattern_generator_cw,
             o_lane_reversal, o_current_die_repeating_reversalmb,
             o_tx_reversalmb_done, o_reversalmb_error
   );

   modport slave (
      output i_REVERSAL_EN, i_rx_msg_valid, i_decoded_SB_msg, i_rx_data_bus,
             i_SB_Busy, i_falling_edge_busy, i_rx_wrapper_valid, i_pattern_gen_done,
      input  o_encoded_SB_msg_tx, o_valid_tx, o_mainband_pattern_generator_cw,
             o_lane_reversal, o_current_die_repeating_reversalmb,
             o_tx_reversalmb_done, o_reversalmb_error
   );
endinterface

// File: rtl/reversalmb_module_initiator_lane_popcount.sv
// Counts set lanes in a REVERSALMB result and flags a pass when the count
// is strictly above the threshold.
module reversalmb_lane_popcount #(
   parameter int LANES          = 16,
   parameter int PASS_THRESHOLD = 8
) (
   input  logic [LANES-1:0] lanes_i,
   output logic             pass_o
);
   localparam int CNT_W = $clog2(LANES + 1);

   logic [CNT_W-1:0] count;

   always_comb begin
      count = '0;
      for (int i = 0; i < LANES; i++) begin
         count = count + CNT_W'(lanes_i[i]);
      end
      pass_o = int'(count) > PASS_THRESHOLD;
   end

endmodule

// File: rtl/reversalmb_module_initiator.sv
// Local-module side of the MBINIT REVERSALMB handshake: requests over the
// sideband, drives the per-lane ID generator, retries once with lane reversal.
//
//   state               | meaning
//   ST_IDLE             | step disabled, all outputs cleared
//   ST_SEND_*_REQ       | request queued/sent on sideband, wait for valid to fall
//   ST_WAIT_*_RESP      | wait for the matching response code
//   ST_SEND_PATTERN     | generator sends per-lane ID pattern
//   ST_EVALUATE         | judge latched result: done, reversal retry, or error
//   ST_TEST_FINISHED    | step passed, hold until enable drops
//   ST_ERROR            | failed after reversal, hold until enable drops
module reversalmb_module_initiator
   import reversalmb_module_initiator_pkg::*;
#(
   parameter int LANES          = RMB_LANES,
   parameter int PASS_THRESHOLD = RMB_PASS_THRESHOLD
) (
   input logic                           i_clk,
   input logic                           i_rst_n,
   reversalmb_module_initiator_if.master sb
);

   rmb_state_e       state_q, state_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             valid_dly_q, valid_dly_d;
   logic             pending_q, pending_d;
   logic [1:0]       cw_q, cw_d;
   logic             lane_rev_q, lane_rev_d;
   logic             retry_q, retry_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [LANES-1:0] result_q, result_d;

   logic             result_pass;
   logic             valid_fell;
   logic             rx_valid;
   logic [3:0]       rx_code;

   reversalmb_lane_popcount #(
      .LANES          (LANES),
      .PASS_THRESHOLD (PASS_THRESHOLD)
   ) u_popcount (
      .lanes_i (result_q),
      .pass_o  (result_pass)
   );

   assign rx_valid   = sb.i_rx_msg_valid;
   assign rx_code    = sb.i_decoded_SB_msg;
   assign valid_fell = valid_dly_q && !valid_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= '0;
         valid_q     <= 1'b0;
         valid_dly_q <= 1'b0;
         pending_q   <= 1'b0;
         cw_q        <= CW_IDLE;
         lane_rev_q  <= 1'b0;
         retry_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         valid_dly_q <= valid_dly_d;
         pending_q   <= pending_d;
         cw_q        <= cw_d;
         lane_rev_q  <= lane_rev_d;
         retry_q     <= retry_d;
         done_q      <= done_d;
         err_q       <= err_d;
         result_q    <= result_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      valid_d     = valid_q;
      valid_dly_d = valid_q;
      pending_d   = pending_q;
      cw_d        = cw_q;
      lane_rev_d  = lane_rev_q;
      retry_d     = 1'b0;
      done_d      = done_q;
      err_d       = err_q;
      result_d    = result_q;

      // Every request entry arms pending; valid waits for a free sideband path.
      if (sb.i_falling_edge_busy) begin
         valid_d = 1'b0;
      end else if (pending_q && is_send_state(state_q) &&
                   !sb.i_SB_Busy && !sb.i_rx_wrapper_valid) begin
         valid_d   = 1'b1;
         pending_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (sb.i_REVERSAL_EN) begin
               state_d   = ST_SEND_INIT_REQ;
               code_d    = MSG_INIT_REQ;
               pending_d = 1'b1;
            end
         end
         ST_SEND_INIT_REQ:   if (valid_fell) state_d = ST_WAIT_INIT_RESP;
         ST_WAIT_INIT_RESP: begin
            if (rx_valid && rx_code == MSG_INIT_RESP) begin
               state_d   = ST_SEND_CLEAR_REQ;
               code_d    = MSG_CLEAR_ERROR_REQ;
               pending_d = 1'b1;
            end
         end
         ST_SEND_CLEAR_REQ:  if (valid_fell) state_d = ST_WAIT_CLEAR_RESP;
         ST_WAIT_CLEAR_RESP: begin
            if (rx_valid && rx_code == MSG_CLEAR_ERROR_RESP) begin
               state_d = ST_SEND_PATTERN;
               cw_d    = CW_CLEAR_LFSR;
            end
         end
         ST_SEND_PATTERN: begin
            if (sb.i_pattern_gen_done) begin
               state_d   = ST_SEND_RESULT_REQ;
               code_d    = MSG_RESULT_REQ;
               pending_d = 1'b1;
               cw_d      = CW_IDLE;
            end else begin
               cw_d = CW_SEND_ID;
            end
         end
         ST_SEND_RESULT_REQ: if (valid_fell) state_d = ST_WAIT_RESULT_RESP;
         ST_WAIT_RESULT_RESP: begin
            if (rx_valid && rx_code == MSG_RESULT_RESP) begin
               state_d  = ST_EVALUATE;
               result_d = sb.i_rx_data_bus;
            end
         end
         ST_EVALUATE: begin
            if (result_pass) begin
               state_d   = ST_SEND_DONE_REQ;
               code_d    = MSG_DONE_REQ;
               pending_d = 1'b1;
            end else if (!lane_rev_q) begin
               state_d    = ST_SEND_CLEAR_REQ;
               code_d     = MSG_CLEAR_ERROR_REQ;
               pending_d  = 1'b1;
               lane_rev_d = 1'b1;
               retry_d    = 1'b1;
            end else begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end
         end
         ST_SEND_DONE_REQ:   if (valid_fell) state_d = ST_WAIT_DONE_RESP;
         ST_WAIT_DONE_RESP: begin
            if (rx_valid && rx_code == MSG_DONE_RESP) begin
               state_d = ST_TEST_FINISHED;
               done_d  = 1'b1;
            end
         end
         ST_TEST_FINISHED, ST_ERROR: state_d = state_q;
         default:                    state_d = ST_IDLE;
      endcase

      if (!sb.i_REVERSAL_EN) begin
         state_d     = ST_IDLE;
         code_d      = '0;
         valid_d     = 1'b0;
         valid_dly_d = 1'b0;
         pending_d   = 1'b0;
         cw_d        = CW_IDLE;
         lane_rev_d  = 1'b0;
         retry_d     = 1'b0;
         done_d      = 1'b0;
         err_d       = 1'b0;
         result_d    = '0;
      end
   end

   assign sb.o_encoded_SB_msg_tx                = code_q;
   assign sb.o_valid_tx                         = valid_q;
   assign sb.o_mainband_pattern_generator_cw    = cw_q;
   assign sb.o_lane_reversal                    = lane_rev_q;
   assign sb.o_current_die_repeating_reversalmb = retry_q;
   assign sb.o_tx_reversalmb_done               = done_q;
   assign sb.o_reversalmb_error                 = err_q;

endmodule
